// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and controller state type for ahb_slave_ctrl.
// Optional wait timeout in the controller is enabled with AHB_CTRL_TIMEOUT_EN.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } ctrl_state_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Peripherals are at most word-wide; anything larger is rejected.
    function automatic logic size_legal(input logic [2:0] size);
        return size <= HSIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb_slave_ctrl_if.sv
// AHB-Lite slave-port signal bundle between the decoder/mux and ahb_slave_ctrl.
// The master modport represents the bus fabric side (including the muxed HREADY).
interface ahb_slave_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_wait_timer.sv
// Saturating wait-state counter for ahb_slave_ctrl; instantiated only when
// AHB_CTRL_TIMEOUT_EN is defined.
module ahb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  MAX  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
    assign expire = inc && (cnt >= LAST);

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave controller: turns address/data phases into peripheral strobes,
// stalls on per_done, and maps per_check to a two-cycle ERROR. Macro: AHB_CTRL_TIMEOUT_EN.
module ahb_slave_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    ahb_slave_ctrl_if.slave   ahb,
    output logic              per_en,
    output logic [ADDR_W-1:0] per_addr,
    output logic [1:0]        per_size,
    output logic              per_we,
    output logic              per_re,
    output logic [31:0]       per_wdata,
    input  logic [31:0]       per_rdata,
    input  logic              per_done,
    input  logic              per_check
);
    ctrl_state_e state, state_nxt, follow;
    logic        reg_write;
    logic        accept;
    logic        legal;
    logic        expire;

    assign accept    = ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];
    assign legal     = size_legal(ahb.HSIZE);
    assign per_wdata = ahb.HWDATA;

    // Where a finished (or idle) data phase hands over to.
    assign follow = !accept ? ST_IDLE : (legal ? ST_ACCESS : ST_ERR1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            per_addr  <= '0;
            per_size  <= '0;
            reg_write <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                per_addr  <= ahb.HADDR[ADDR_W-1:0];
                per_size  <= ahb.HSIZE[1:0];
                reg_write <= ahb.HWRITE;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = HRESP_OKAY;
        ahb.HRDATA    = '0;
        per_en        = 1'b0;
        per_we        = 1'b0;
        per_re        = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = follow;
            end
            ST_ACCESS: begin
                per_en        = 1'b1;
                per_we        = reg_write;
                per_re        = !reg_write;
                ahb.HREADYOUT = 1'b0;
                // check outranks done, done outranks the timeout
                if (per_check) begin
                    state_nxt = ST_ERR1;
                end else if (per_done) begin
                    ahb.HREADYOUT = 1'b1;
                    if (!reg_write) ahb.HRDATA = per_rdata;
                    state_nxt = follow;
                end else if (expire) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = HRESP_ERROR;
                state_nxt     = ST_ERR2;
            end
            ST_ERR2: begin
                ahb.HRESP = HRESP_ERROR;
                state_nxt = follow;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef AHB_CTRL_TIMEOUT_EN
    logic timer_clr;
    logic timer_inc;

    // Clear on every entry into ACCESS, including back-to-back re-entry.
    assign timer_clr = (state_nxt == ST_ACCESS) && (state != ST_ACCESS || per_done);
    assign timer_inc = (state == ST_ACCESS) && !per_done;

    ahb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expire (expire)
    );

    logic unused_addr;
    assign unused_addr = ^ahb.HADDR;
`else
    assign expire = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{ahb.HADDR, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Scoreboard bench for ahb_slave_ctrl: random AHB transfers against a
// transfer-level model of response length, error and strobe contents.
module tb_ahb_slave_ctrl;
    import ahb_pkg::*;

    localparam int TMO = 3;
`ifdef AHB_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        chk;
    } txn_t;

    typedef struct {
        int          len;     // data-phase cycles until HREADYOUT=1
        int          en_cyc;  // leading cycles with per_en=1
        logic        err;
        logic        write;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          waits;
        logic        chk;
        logic [31:0] rdata;
    } pcfg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_slave_ctrl_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    logic        per_en, per_we, per_re, per_done, per_check;
    logic [15:0] per_addr;
    logic [1:0]  per_size;
    logic [31:0] per_wdata, per_rdata;

    ahb_slave_ctrl #(
        .ADDR_W         (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ahb       (bus),
        .per_en    (per_en),
        .per_addr  (per_addr),
        .per_size  (per_size),
        .per_we    (per_we),
        .per_re    (per_re),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata),
        .per_done  (per_done),
        .per_check (per_check)
    );

    int    n_chk = 0;
    int    n_fail = 0;
    exp_t  exp_q[$];
    pcfg_t per_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.write = t.write;
        e.addr  = t.addr[15:0];
        e.size  = t.size[1:0];
        e.wdata = t.wdata;
        e.rdata = t.rdata;
        if (t.size > 3'd2) begin
            e.len = 2; e.en_cyc = 0; e.err = 1'b1;
        end else if (t.chk) begin
            e.len = 3; e.en_cyc = 1; e.err = 1'b1;
        end else if (TO_EN && t.waits >= TMO) begin
            e.len = TMO + 2; e.en_cyc = TMO; e.err = 1'b1;
        end else begin
            e.len = t.waits + 1; e.en_cyc = t.waits + 1; e.err = 1'b0;
        end
        return e;
    endfunction

    // Peripheral model: done after 'waits' stalled cycles, check held for the phase.
    pcfg_t cur;
    int    wcnt;
    assign per_done  = per_en && (wcnt == cur.waits);
    assign per_check = per_en && cur.chk;
    assign per_rdata = cur.rdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            per_q.delete();
            cur  <= '{waits: 0, chk: 1'b0, rdata: 32'h0};
            wcnt <= 0;
        end else if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
            cur  <= per_q.pop_front();
            wcnt <= 0;
        end else if (per_en && !per_done) begin
            wcnt <= wcnt + 1;
        end
    end

    // Monitor: tracks data phases and scores every cycle.
    logic dp_active = 1'b0;
    logic mon_on = 1'b0;
    int   len = 0;

    initial begin
        exp_t e;
        logic exp_rdy, exp_resp, exp_en;
        logic [31:0] exp_rdata;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                if (dp_active && exp_q.size() > 0) e = exp_q.pop_front();
                dp_active = 1'b0;
                mon_on    = 1'b1;
            end else if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
                dp_active = 1'b1;
                len       = 0;
            end
            @(negedge clk);
            if (!mon_on) continue;
            if (dp_active) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: data phase with no expected entry at %0t", $time);
                    dp_active = 1'b0;
                    continue;
                end
                len++;
                e = exp_q[0];
                exp_rdy   = (len == e.len);
                exp_resp  = e.err && (len >= e.len - 1);
                exp_en    = (len <= e.en_cyc);
                exp_rdata = (exp_rdy && !e.err && !e.write) ? e.rdata : 32'h0;
                chk("phase{rdy,resp,en,rdata}",
                    64'({bus.HREADYOUT, bus.HRESP, per_en, bus.HRDATA}),
                    64'({exp_rdy, exp_resp, exp_en, exp_rdata}));
                if (exp_en && per_en === 1'b1)
                    chk("strobe{addr,size,we,re,wdata}",
                        64'({per_addr, per_size, per_we, per_re, per_wdata}),
                        64'({e.addr, e.size, e.write, !e.write, e.wdata}));
                if (bus.HREADYOUT === 1'b1 || len >= e.len) begin
                    e = exp_q.pop_front();
                    dp_active = 1'b0;
                end
            end else begin
                chk("idle{rdy,resp,en,rdata}",
                    64'({bus.HREADYOUT, bus.HRESP, per_en, bus.HRDATA}),
                    64'({1'b1, 1'b0, 1'b0, 32'h0}));
            end
        end
    end

    // Driver: called at a negedge, returns at the negedge after acceptance.
    task automatic issue(input txn_t t);
        logic  r;
        int    guard;
        pcfg_t p;
        p.waits = t.waits;
        p.chk   = t.chk;
        p.rdata = t.rdata;
        per_q.push_back(p);
        exp_q.push_back(model(t));
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = t.addr;
        bus.HWRITE = t.write;
        bus.HSIZE  = t.size;
        guard = 0;
        forever begin
            #1;
            r = bus.HREADY;
            @(posedge clk);
            if (r === 1'b1) break;
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                $display("FAIL issue_timeout: HREADY stuck low got %b expected 1", r);
                n_fail++;
                $fatal(1, "bus stalled");
            end
        end
        #1;
        bus.HWDATA = t.wdata;
        @(negedge clk);
        bus.HTRANS = HTRANS_IDLE;
    endtask

    task automatic gap(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            bus.HSEL   = (kind != 2);
            bus.HTRANS = (kind == 1) ? HTRANS_BUSY : (kind == 2) ? HTRANS_NONSEQ : HTRANS_IDLE;
            bus.HADDR  = $urandom;
            @(negedge clk);
        end
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_IDLE;
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int wt, input logic c);
        txn_t t;
        t.write = w; t.addr = a; t.size = s; t.wdata = wd;
        t.rdata = rd; t.waits = wt; t.chk = c;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   r;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0; bus.HSIZE = 3'b010; bus.HWDATA = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a stalled read.
        issue(mk(1'b0, 32'h0000_0040, 3'd2, 32'h0, 32'hDEAD_BEEF, 20, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(mk(1'b0, 32'h0000_0003, 3'd2, 32'h1111_2222, 32'h5, 0, 1'b0));
        gap(1, 0);
        issue(mk(1'b1, 32'h0000_FF00, 3'd2, 32'h0000_00A5, 32'h0, 0, 1'b0));
        issue(mk(1'b0, 32'h0000_00FF, 3'd0, 32'h0, 32'h1234_5678, 0, 1'b0));
        issue(mk(1'b1, 32'h0000_0010, 3'd2, 32'hCAFE_0001, 32'h0, 0, 1'b1));
        gap(2, 0);
        issue(mk(1'b1, 32'h0000_0014, 3'd3, 32'hCAFE_0002, 32'h0, 0, 1'b0));
        gap(2, 0);
        issue(mk(1'b0, 32'h0000_0020, 3'd2, 32'h0, 32'h0BAD_F00D, 4, 1'b0));
        issue(mk(1'b0, 32'h0000_0024, 3'd1, 32'h0, 32'h7777_8888, 5, 1'b0));
        gap(2, 1);
        gap(2, 2);
        gap(1, 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            t.write = 1'($urandom_range(0, 1));
            t.addr  = $urandom;
            t.size  = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.waits = $urandom_range(0, 5);
            t.chk   = ($urandom_range(0, 7) == 0);
            issue(t);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3), $urandom_range(0, 2));
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'h0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_ctrl.md
Name: ahb_slave_ctrl

Overview:
AHB-Lite slave-side controller that turns AHB address/data phases into single-cycle peripheral strobes (en/we/re/Addr/size/wd_data) for GPIO-class slaves.
- Stalls the bus while the peripheral holds done low.
- Converts the peripheral's combinational check flag into a compliant two-cycle ERROR response.
- Sits between the AHB decoder/mux and one peripheral instance. One instance per slave.

Parameters:
ADDR_W, 16, peripheral address/mask width; per_addr = HADDR[ADDR_W-1:0].
TIMEOUT_CYCLES, 15, max wait-state cycles before forced ERROR (used only with AHB_CTRL_TIMEOUT_EN); must be >= 1.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
HSEL  in  1  slave select from decoder.
HADDR  in  32  address-phase address.
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
HWRITE  in  1  address-phase direction.
HSIZE  in  3  transfer size.
HWDATA  in  32  data-phase write data.
HREADY  in  1  bus-level ready (muxed HREADYOUT of the active slave).
HRDATA  out  32  read data.
HREADYOUT  out  1  this slave's ready.
HRESP  out  1  0=OKAY, 1=ERROR.
per_en  out  1  peripheral select, data phase only.
per_addr  out  ADDR_W  registered address/mask.
per_size  out  2  registered HSIZE[1:0].
per_we  out  1  write strobe.
per_re  out  1  read strobe.
per_wdata  out  32  equals HWDATA (combinational pass-through).
per_rdata  in  32  peripheral read data.
per_done  in  1  peripheral completion.
per_check  in  1  peripheral error flag (combinational in data phase).

Behaviour:
- Reset values, applied whenever rst_n=0 at a clock edge: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, per_en/per_we/per_re=0, per_addr=0, per_size=0, wait counter=0.
- Reset mid-transfer aborts the transfer with no further strobes.
- Transfer accept condition: `HSEL && HREADY && HTRANS[1]` at a rising edge. BUSY and IDLE are ignored and give OKAY with zero wait.
- On accept, register HADDR, HWRITE and HSIZE.
- HSIZE > 3'b010 is an illegal size: go to ERR1 directly and never assert per_en.
- States:
  - IDLE: HREADYOUT=1, HRESP=0, no strobes.
  - ACCESS: per_en=1; per_we=reg_write; per_re=!reg_write.
    - Exit conditions:
      - per_check=1 -> ERR1. The check result takes priority over per_done.
      - per_done=1 and per_check=0 -> HREADYOUT=1, HRDATA=per_rdata for reads (0 for writes).
      - Otherwise stay in ACCESS with HREADYOUT=0 (wait state).
    - Next state after a completed transfer: ACCESS if a new transfer is accepted in the same cycle (back-to-back, zero bubble), else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, strobes low -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state is ACCESS if a transfer is accepted (or ERR1 for an illegal size), else IDLE.
- Minimum latency is 1 data-phase cycle (zero wait).
- A peripheral write that reports check still commits the masked bits on the ACCESS edge; the error is reported, not rolled back.
- HRDATA=0 in every cycle that is not a completing read.
- HREADYOUT, HRESP and the strobes are decoded from the registered state plus per_done/per_check. No combinational path from HADDR/HTRANS to the outputs.

Optional Feature:
AHB_CTRL_TIMEOUT_EN
- Defined: a wait counter clears on entry to ACCESS and increments each ACCESS cycle with per_done=0. When the count reaches TIMEOUT_CYCLES, go to ERR1. The counter saturates and never wraps.
- Undefined: no counter; a peripheral that never asserts done stalls the bus indefinitely.

Decomposition:
- Package ahb_pkg:
  - htrans_e enum (IDLE/BUSY/NONSEQ/SEQ).
  - hresp constants OKAY/ERROR.
  - ctrl_state_e enum (IDLE, ACCESS, ERR1, ERR2).
  - HSIZE_WORD=3'b010.
- Optional sub-module ahb_wait_timer (counter, clear/inc, expire flag), instantiated only under AHB_CTRL_TIMEOUT_EN.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-ACCESS -> next cycle HREADYOUT=1, HRESP=0, per_en=0, state IDLE.
- Read: NONSEQ read HADDR=0x0000_0003, per_done=1, per_rdata=0x5 -> one data cycle, per_re=1, per_addr=0x0003, HRDATA=0x5, HRESP=0.
- Back-to-back: write 0xA5 to mask 0xFF00 then read mask 0x00FF, each issued on the prior ready cycle -> two consecutive ACCESS cycles, no IDLE gap, per_wdata=0xA5 in the first.
- Error: write with per_check=1 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. Repeat with HSIZE=3'b011 -> same response, per_en never asserted.
- Wait states: per_done low for 4 cycles -> HREADYOUT=0 for 4 cycles, completes on the 5th. With AHB_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=3 -> ERR1 after 3 wait cycles.
- BUSY/IDLE and HSEL=0: HTRANS=01 or HSEL=0 -> no strobes, HREADYOUT=1, HRESP=0.
